// File: rtl/axil_arb_pkg.sv
// Shared types and constants for the two-requester AXI4-Lite command arbiter.
// Holds the FSM state encoding, the fixed PROT value and the AXI response codes.
package axil_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WAIT_B,
    ST_RD_A,
    ST_WAIT_R,
    ST_RESP
  } arb_state_t;

  localparam logic [2:0] AXI_PROT    = 3'b000;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // last_one = 1 means requester 1 was granted last, so requester 0 wins a tie.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_one);
    logic [1:0] gnt;
    gnt = 2'b00;
    if (last_one) begin
      if (req[0])      gnt = 2'b01;
      else if (req[1]) gnt = 2'b10;
    end else begin
      if (req[1])      gnt = 2'b10;
      else if (req[0]) gnt = 2'b01;
    end
    return gnt;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: combinational one-hot grant, priority rotates
// only when the caller accepts the grant via advance.
module rr_arbiter_2
  import axil_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_one_reg;

  assign grant = rr_pick(req, last_one_reg);

  // Reset value 1 makes requester 0 the first choice after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_one_reg <= 1'b1;
    end else if (advance && (|grant)) begin
      last_one_reg <= grant[1];
    end
  end

endmodule

// File: rtl/axil_req_arbiter.sv
// Arbitrates two simple command ports onto one AXI4-Lite master with a single
// transaction outstanding; completion is returned as a one-hot rsp_valid pulse.
module axil_req_arbiter
  import axil_arb_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_W-1:0]     req_addr,
  input  logic [2*DATA_W-1:0]     req_wdata,
  input  logic [2*DATA_W/8-1:0]   req_wstrb,
  output logic [1:0]              rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic [ADDR_W-1:0]       M_AXI_AWADDR,
  output logic [2:0]              M_AXI_AWPROT,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [DATA_W-1:0]       M_AXI_WDATA,
  output logic [DATA_W/8-1:0]     M_AXI_WSTRB,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  output logic [ADDR_W-1:0]       M_AXI_ARADDR,
  output logic [2:0]              M_AXI_ARPROT,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,
  input  logic [DATA_W-1:0]       M_AXI_RDATA,
  input  logic [1:0]              M_AXI_RRESP,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY
);

  localparam int STRB_W = DATA_W / 8;

  arb_state_t          state_reg;
  logic [1:0]          gnt_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [STRB_W-1:0]   wstrb_reg;
  logic                awvalid_reg;
  logic                wvalid_reg;
  logic                bready_reg;
  logic                arvalid_reg;
  logic                rready_reg;
  logic [1:0]          rsp_valid_reg;
  logic [DATA_W-1:0]   rsp_rdata_reg;
  logic [1:0]          rsp_resp_reg;

  logic [1:0]          grant;
  logic                arb_advance;
  logic                sel;
  logic                aw_done;
  logic                w_done;

  logic [ADDR_W-1:0]   addr_arr  [2];
  logic [DATA_W-1:0]   wdata_arr [2];
  logic [STRB_W-1:0]   wstrb_arr [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
      assign wstrb_arr[gi] = req_wstrb[gi*STRB_W +: STRB_W];
    end
  endgenerate

  assign arb_advance = (state_reg == ST_IDLE);

  rr_arbiter_2 u_rr (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .req     (req_valid),
    .advance (arb_advance),
    .grant   (grant)
  );

  assign sel = grant[1];

  // Accept is combinational with req_valid so the grant cycle is the handshake
  // cycle; it is also forced low while reset is asserted.
  assign req_ready = (arb_advance && ARESETN) ? grant : 2'b00;

  // A channel counts as done once its VALID has dropped or is being accepted now.
  assign aw_done = !awvalid_reg || M_AXI_AWREADY;
  assign w_done  = !wvalid_reg  || M_AXI_WREADY;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_reg     <= ST_IDLE;
      gnt_reg       <= 2'b00;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      awvalid_reg   <= 1'b0;
      wvalid_reg    <= 1'b0;
      bready_reg    <= 1'b0;
      arvalid_reg   <= 1'b0;
      rready_reg    <= 1'b0;
      rsp_valid_reg <= 2'b00;
      rsp_rdata_reg <= '0;
      rsp_resp_reg  <= RESP_OKAY;
    end else begin
      rsp_valid_reg <= 2'b00;
      case (state_reg)
        ST_IDLE: begin
          if (|grant) begin
            gnt_reg   <= grant;
            addr_reg  <= {addr_arr[sel][ADDR_W-1:2], 2'b00};
            wdata_reg <= wdata_arr[sel];
            wstrb_reg <= wstrb_arr[sel];
            if (req_write[sel]) begin
              state_reg   <= ST_WR;
              awvalid_reg <= 1'b1;
              wvalid_reg  <= 1'b1;
            end else begin
              state_reg   <= ST_RD_A;
              arvalid_reg <= 1'b1;
            end
          end
        end
        ST_WR: begin
          if (M_AXI_AWREADY) awvalid_reg <= 1'b0;
          if (M_AXI_WREADY)  wvalid_reg  <= 1'b0;
          if (aw_done && w_done) begin
            state_reg  <= ST_WAIT_B;
            bready_reg <= 1'b1;
          end
        end
        ST_WAIT_B: begin
          if (M_AXI_BVALID) begin
            bready_reg    <= 1'b0;
            rsp_resp_reg  <= M_AXI_BRESP;
            rsp_rdata_reg <= '0;
            rsp_valid_reg <= gnt_reg;
            state_reg     <= ST_RESP;
          end
        end
        ST_RD_A: begin
          if (M_AXI_ARREADY) begin
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b1;
            state_reg   <= ST_WAIT_R;
          end
        end
        ST_WAIT_R: begin
          if (M_AXI_RVALID) begin
            rready_reg    <= 1'b0;
            rsp_resp_reg  <= M_AXI_RRESP;
            rsp_rdata_reg <= M_AXI_RDATA;
            rsp_valid_reg <= gnt_reg;
            state_reg     <= ST_RESP;
          end
        end
        ST_RESP: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign M_AXI_AWADDR  = addr_reg;
  assign M_AXI_AWPROT  = AXI_PROT;
  assign M_AXI_AWVALID = awvalid_reg;
  assign M_AXI_WDATA   = wdata_reg;
  assign M_AXI_WSTRB   = wstrb_reg;
  assign M_AXI_WVALID  = wvalid_reg;
  assign M_AXI_BREADY  = bready_reg;
  assign M_AXI_ARADDR  = addr_reg;
  assign M_AXI_ARPROT  = AXI_PROT;
  assign M_AXI_ARVALID = arvalid_reg;
  assign M_AXI_RREADY  = rready_reg;

  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_resp  = rsp_resp_reg;

endmodule

// File: doc/axil_req_arbiter.md
AXIL_REQ_ARBITER -- requirements
Module: axil_req_arbiter

Interface
REQ-001 Parameter ADDR_W, default 4, AXI4-Lite address width in bits.
REQ-002 Parameter DATA_W, default 32, AXI4-Lite data width in bits; fixed at 32.
REQ-003 ACLK  in  1  single block clock; all logic is rising-edge.
REQ-004 ARESETN  in  1  asynchronous active-low reset.
REQ-005 req_valid  in  2  per-requester command valid; index 0 and index 1.
REQ-006 req_ready  out  2  one-cycle accept pulse to the granted requester.
REQ-007 req_write  in  2  per-requester command type: 1 = write, 0 = read.
REQ-008 req_addr  in  2*ADDR_W  packed per-requester byte address.
REQ-009 req_wdata  in  2*DATA_W  packed per-requester write data.
REQ-010 req_wstrb  in  2*DATA_W/8  packed per-requester write strobes.
REQ-011 rsp_valid  out  2  one-hot, one-cycle completion pulse.
REQ-012 rsp_rdata  out  DATA_W  read data; 0 for writes.
REQ-013 rsp_resp  out  2  forwarded BRESP or RRESP.
REQ-014 M_AXI_AWADDR/AWPROT/AWVALID  out  ADDR_W/3/1  and AWREADY  in  1  write address channel.
REQ-015 M_AXI_WDATA/WSTRB/WVALID  out  DATA_W/DATA_W/8/1  and WREADY  in  1  write data channel.
REQ-016 M_AXI_BRESP/BVALID  in  2/1  and BREADY  out  1  write response channel.
REQ-017 M_AXI_ARADDR/ARPROT/ARVALID  out  ADDR_W/3/1  and ARREADY  in  1  read address channel.
REQ-018 M_AXI_RDATA/RRESP/RVALID  in  DATA_W/2/1  and RREADY  out  1  read data channel.

Function
REQ-019 The FSM SHALL have states IDLE, WR, WAIT_B, RD_A, WAIT_R, RESP, with one transaction outstanding at a time.
REQ-020 In IDLE with any req_valid set, the block SHALL grant one requester round-robin, with the last-granted requester at lowest priority.
REQ-021 On grant, the block SHALL pulse req_ready for exactly one cycle and latch the request's write flag, address (bits [1:0] forced to 0), wdata and wstrb.
REQ-022 A granted write SHALL move to WR, asserting AWVALID and WVALID together on the next cycle.
REQ-023 In WR, each VALID SHALL drop independently after its own handshake; same-cycle AWREADY and WREADY SHALL complete both channels.
REQ-024 WR SHALL go to WAIT_B when both channels are done; WAIT_B SHALL hold BREADY=1 until BVALID, capture BRESP, then go to RESP.
REQ-025 A granted read SHALL move to RD_A with ARVALID=1 until ARREADY, then to WAIT_R with RREADY=1 until RVALID, capturing RDATA and RRESP.
REQ-026 RESP SHALL pulse rsp_valid[granted] for one cycle with the captured data and response, then return to IDLE.
REQ-027 An asserted VALID and its payload SHALL stay stable until the matching READY.
REQ-028 AWPROT and ARPROT SHALL be 3'b000.
REQ-029 Minimum latency SHALL be: grant at T, AW/W at T+1, rsp_valid at T+3 with zero-wait slave.
REQ-030 req_valid changes outside the grant cycle SHALL be ignored.
REQ-031 Non-OKAY responses SHALL be forwarded unmodified; no retry.

Reset
REQ-032 On ARESETN low, the block SHALL asynchronously clear all VALID, READY, req_ready, rsp_valid, rsp_rdata and rsp_resp to 0, set the state to IDLE and give requester 0 top priority.
REQ-033 Reset mid-transaction SHALL abandon the transaction and issue no rsp_valid.

Structure
REQ-034 Package axil_arb_pkg SHALL hold the state enum, the PROT constant and the OKAY/SLVERR/DECERR codes.
REQ-035 Round-robin grant logic SHALL be sub-module rr_arbiter_2 (req[1:0], advance -> grant one-hot).

Verification
REQ-036 Write via req0 of 0x00000002 to 0x4 -> AWADDR=0x4, WDATA=0x00000002, rsp_valid=2'b01, rsp_resp=0; read via req0 of 0x4 -> rsp_rdata=0x00000002.
REQ-037 req1 writes 1,2,3,4 to 0x0,0x4,0x8,0xC, then req0 reads all four -> data matches 1..4.
REQ-038 Both req_valid held high from reset -> grant order 0,1,0,1, with no back-to-back double grant.
REQ-039 Slave gives AWREADY at cycle 1 and WREADY at cycle 4 -> AWVALID low after cycle 1, WVALID and WDATA stable through cycle 4, exactly one rsp_valid.
REQ-040 Slave returns BRESP=2'b10 -> rsp_resp=2'b10; RRESP=2'b11 on a read -> rsp_resp=2'b11.
REQ-041 ARESETN low while ARVALID=1 -> ARVALID low without waiting for a clock edge, no rsp_valid; after release, a simultaneous request grants req0.
